// File: rtl/btn_debounce_if.sv
// Button-side signal bundle for btn_debounce: raw pin levels in, clean levels and strobes out.
// The master side drives btn_raw; the slave side (the debouncer) drives everything else.
interface btn_debounce_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic [NUM_BTNS-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-button synchroniser, stability-counter debouncer and press/release/long-press strobe generator.
// Long-press detection is compiled in only when BTN_LONG_PRESS_EN is defined; otherwise btn_long is 0.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   IDLE        | stable released, level 0
//   PRESS_CHK   | s2 went high, counting stable-high cycles
//   PRESSED     | stable pressed, level 1
//   RELEASE_CHK | s2 went low, counting stable-low cycles, level 1
module btn_debounce #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LONG_CYCLES     = 24000000
) (
    input  logic           CLK,
    input  logic           RST,
    btn_debounce_if.slave  btn
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        logic          s1;
        logic          s2;
        state_t        state;
        logic [DW-1:0] cnt;
        logic          level;
        logic          press;
        logic          rel;
        logic          long_p;

        always_ff @(posedge CLK) begin
            if (RST) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                s1    <= btn.btn_raw[i];
                s2    <= s1;
                press <= 1'b0;
                rel   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s2) begin
                            state <= PRESS_CHK;
                            cnt   <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!s2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == D_LAST) begin
                            state <= PRESSED;
                            cnt   <= '0;
                            press <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s2) begin
                            state <= RELEASE_CHK;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_CHK: begin
                        if (s2) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == D_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            rel   <= 1'b1;
                            level <= 1'b0;
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

`ifdef BTN_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CYCLES);
        localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

        logic [LW-1:0] hold;
        logic          hold_done;

        // hold_done keeps the saturated counter from re-firing; a release-bounce back to PRESSED keeps it
        always_ff @(posedge CLK) begin
            if (RST) begin
                hold      <= '0;
                hold_done <= 1'b0;
                long_p    <= 1'b0;
            end else begin
                long_p <= 1'b0;
                if (state == PRESS_CHK && s2 && cnt == D_LAST) begin
                    hold      <= '0;
                    hold_done <= 1'b0;
                end else if ((state == PRESSED || state == RELEASE_CHK) && !hold_done) begin
                    if (hold == L_LAST) begin
                        long_p    <= 1'b1;
                        hold_done <= 1'b1;
                    end else begin
                        hold <= hold + LW'(1);
                    end
                end
            end
        end
`else
        assign long_p = 1'b0;
`endif

        assign btn.btn_level[i]   = level;
        assign btn.btn_press[i]   = press;
        assign btn.btn_release[i] = rel;
        assign btn.btn_long[i]    = long_p;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity, checked every cycle
// against a run-length reference model of the debounce rules.
module tb_btn_debounce;
    localparam int N = 4;
    localparam int D = 8;
    localparam int L = 32;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    btn_debounce_if #(.NUM_BTNS(N)) bif ();

    btn_debounce #(
        .NUM_BTNS(N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .btn(bif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: raw delayed two samples, level flips after D+1 consecutive disagreeing samples
    logic [N-1:0] m_p1, m_p2, m_lvl, m_press, m_rel, m_long;
    int m_run [N];
    int m_held[N];

    int press_cnt[N], rel_cnt[N], long_cnt[N];
    int last_press[N], last_rel[N], last_long[N];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic rst);
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int b = 0; b < N; b++) begin
                m_run[b]  = 0;
                m_held[b] = 0;
            end
        end else begin
            m_press = '0; m_rel = '0; m_long = '0;
            for (int b = 0; b < N; b++) begin
                if (m_lvl[b]) begin
                    m_held[b]++;
                    if (m_held[b] == L) m_long[b] = LONG_ON;
                end
                if (m_p2[b] != m_lvl[b]) m_run[b]++;
                else                     m_run[b] = 0;
                if (m_run[b] == D + 1) begin
                    m_run[b] = 0;
                    if (m_lvl[b]) begin
                        m_lvl[b] = 1'b0;
                        m_rel[b] = 1'b1;
                    end else begin
                        m_lvl[b]   = 1'b1;
                        m_press[b] = 1'b1;
                        m_held[b]  = 0;
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = raw;
        end
    endtask

    task automatic clear_counts();
        for (int b = 0; b < N; b++) begin
            press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
            last_press[b] = -1; last_rel[b] = -1; last_long[b] = -1;
        end
    endtask

    task automatic step(input logic [N-1:0] raw, input logic rst);
        bif.btn_raw = raw;
        RST = rst;
        @(posedge CLK);
        cyc++;
        model_edge(raw, rst);
        #1;
        check("level",   bif.btn_level,   m_lvl);
        check("press",   bif.btn_press,   m_press);
        check("release", bif.btn_release, m_rel);
        check("long",    bif.btn_long,    m_long);
        for (int b = 0; b < N; b++) begin
            if (bif.btn_press[b] === 1'b1)   begin press_cnt[b]++; last_press[b] = cyc; end
            if (bif.btn_release[b] === 1'b1) begin rel_cnt[b]++;   last_rel[b]   = cyc; end
            if (bif.btn_long[b] === 1'b1)    begin long_cnt[b]++;  last_long[b]  = cyc; end
        end
    endtask

    task automatic repeat_step(input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    initial begin
        int t0;
        int tp;
        logic [N-1:0] rnd;
        bif.btn_raw = '0;
        RST = 1'b1;
        clear_counts();

        // reset state
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("reset_outputs", bif.btn_level | bif.btn_press | bif.btn_release | bif.btn_long, 4'b0000);
        repeat_step(4'b0000, 4);

        // clean press on button 0
        clear_counts();
        step(4'b0001, 1'b0);
        t0 = cyc;
        repeat_step(4'b0001, 14);
        checki("clean_press_time", last_press[0], t0 + 10);
        checki("clean_press_count", press_cnt[0], 1);
        checki("clean_other_bits", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        repeat_step(4'b0000, 14);

        // bounce reject on button 1, then a clean 10-cycle hold
        clear_counts();
        for (int r = 0; r < 4; r++) begin
            repeat_step(4'b0010, 5);
            repeat_step(4'b0000, 3);
        end
        repeat_step(4'b0000, 12);
        checki("bounce_no_press", press_cnt[1], 0);
        checki("bounce_no_release", rel_cnt[1], 0);
        repeat_step(4'b0010, 10);
        repeat_step(4'b0000, 20);
        checki("bounce_then_press", press_cnt[1], 1);

        // release with glitch on button 0
        repeat_step(4'b0001, 20);
        clear_counts();
        repeat_step(4'b0000, 4);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        t0 = cyc;
        repeat_step(4'b0000, 19);
        checki("glitch_release_count", rel_cnt[0], 1);
        checki("glitch_release_time", last_rel[0], t0 + 10);

        // long press on button 2
        clear_counts();
        for (int k = 0; k < 20 && press_cnt[2] == 0; k++) step(4'b0100, 1'b0);
        tp = last_press[2];
        repeat_step(4'b0100, 60);
        repeat_step(4'b0000, 20);
        checki("long_count", long_cnt[2], LONG_ON ? 1 : 0);
        checki("long_time", last_long[2], LONG_ON ? tp + L : -1);

        // simultaneous press on buttons 0 and 3
        clear_counts();
        step(4'b1001, 1'b0);
        t0 = cyc;
        repeat_step(4'b1001, 14);
        checki("simul_press0", last_press[0], t0 + 10);
        checki("simul_press3", last_press[3], t0 + 10);
        repeat_step(4'b0000, 20);

        // reset while button 0 is mid-debounce
        clear_counts();
        repeat_step(4'b0001, 8);
        step(4'b0001, 1'b1);
        t0 = cyc;
        check("reset_mid_outputs", bif.btn_level | bif.btn_press | bif.btn_release | bif.btn_long, 4'b0000);
        repeat_step(4'b0001, 20);
        checki("reset_mid_press_count", press_cnt[0], 1);
        checki("reset_mid_press_time", last_press[0], t0 + 11);
        repeat_step(4'b0000, 20);

        // random activity with occasional reset
        rnd = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 11) == 0) rnd[b] = ~rnd[b];
            step(rnd, ($urandom_range(0, 399) == 0));
        end
        repeat_step(4'b0000, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounce and edge-detect stage for the stopwatch's push-button inputs. Raw, asynchronous, bouncing button levels from the dedicated input pins are synchronised, filtered by a per-button stability counter, and converted into clean one-cycle press, release and (optionally) long-press strobes. The stopwatch core consumes these strobes in place of the raw input levels. Each button runs its own independent state machine.

## Interface
Parameters:
- NUM_BTNS, 4, number of independent button channels
- DEBOUNCE_CYCLES, 12000, consecutive stable cycles required to accept a level change (1 ms at 12 MHz); legal minimum 2
- LONG_CYCLES, 24000000, cycles in PRESSED before the long-press strobe fires (2 s at 12 MHz); must exceed DEBOUNCE_CYCLES

Ports:
- CLK  input  1  system clock; single clock domain
- RST  input  1  synchronous, active-high reset
- btn_raw  input  NUM_BTNS  raw button levels; asynchronous; 1 = pressed
- btn_level  output  NUM_BTNS  debounced level; 1 = pressed
- btn_press  output  NUM_BTNS  one-cycle strobe on an accepted press
- btn_release  output  NUM_BTNS  one-cycle strobe on an accepted release
- btn_long  output  NUM_BTNS  one-cycle strobe after LONG_CYCLES held; constant 0 when the feature is compiled out

## Operation
- Per bit: 2-flop synchroniser (s1, s2); only s2 feeds the FSM.
- Per-button FSM states: IDLE (stable released), PRESS_CHK, PRESSED (stable pressed), RELEASE_CHK.
- IDLE: s2=1 -> PRESS_CHK with debounce count cleared to 0.
- PRESS_CHK: s2=0 -> IDLE, no strobe. s2=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED with btn_press=1 and btn_level=1. Otherwise count+1.
- PRESSED: s2=0 -> RELEASE_CHK with count cleared to 0.
- RELEASE_CHK: s2=1 -> PRESSED, no strobe. s2=0 and count==DEBOUNCE_CYCLES-1 -> IDLE with btn_release=1 and btn_level=0. Otherwise count+1.
- Debounce counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps; it is cleared on every state entry.
- btn_level is 1 exactly in PRESSED and RELEASE_CHK.
- All outputs are registered.
- Channels are fully independent; simultaneous activity on several buttons yields simultaneous strobes.

## Timing
- Reset: all FSMs go to IDLE; counters and synchronisers clear to 0; btn_level, btn_press, btn_release and btn_long are 0 in the cycle after RST is sampled high. Reset takes effect mid-debounce or mid-hold with no strobe emitted.
- A button held through reset produces btn_press a full debounce period after RST deasserts.
- Press latency: let t0 be the first edge that samples btn_raw=1 into s1, with raw held high. s2=1 after t0+1, PRESS_CHK is entered at t0+2, and btn_press and btn_level are asserted after edge t0+2+DEBOUNCE_CYCLES.
- Release latency is identical, measured from raw going low.
- A strobe is high for exactly one cycle.
- btn_press and btn_release never assert in the same cycle for the same button.
- A bounce of any length shorter than DEBOUNCE_CYCLES produces no strobe and no level change.

## Configuration
- Macro BTN_LONG_PRESS_EN.
- Defined:
  - A per-button hold counter of clog2(LONG_CYCLES) bits clears on entry to PRESSED from PRESS_CHK.
  - It increments in PRESSED and RELEASE_CHK.
  - At count==LONG_CYCLES-1, btn_long pulses for one cycle and the counter saturates; there is no repeat.
  - A bounce back from RELEASE_CHK to PRESSED does not clear the counter.
- Undefined: the hold counter is absent and btn_long is tied to 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, LONG_CYCLES=32, NUM_BTNS=4.
- Clean press: raw[0] rises at t0 and is held -> btn_press[0] is a single pulse after edge t0+10, and btn_level[0]=1 from then on; other bits stay 0.
- Bounce reject: raw[1] toggles high 5 cycles / low 3 cycles, repeated 4 times, then stays low -> no strobe and btn_level[1]=0 throughout. Then raw[1] is held high for 10 cycles -> exactly one btn_press[1].
- Release with glitch: button pressed and stable, raw goes low 4 cycles, high 1 cycle, then low -> one btn_release, issued 10 cycles after the final falling edge.
- Long press (macro on): hold raw[2] for 60 cycles after btn_press -> exactly one btn_long[2] pulse, 32 cycles after btn_press. With the macro off, btn_long stays 0.
- Simultaneous: raw[0] and raw[3] rise on the same edge -> btn_press[0] and btn_press[3] pulse in the same cycle.
- Reset mid-operation: RST pulses for 1 cycle while button 0 is in PRESS_CHK at count 5 with raw held high -> no strobe; all outputs are 0 the next cycle; btn_press[0] fires 10 cycles after RST deasserts.
